// File: rtl/spi_master_n_if.sv
// CPU-side bus of the SPI master: strobe, select, address, data and interrupt.
interface spi_master_n_if;
  logic       nE;
  logic       nSEL;
  logic       RW;
  logic [1:0] A;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       DOE;
  logic       nIRQ;

  modport master (output nE, nSEL, RW, A, DIN, input DOUT, DOE, nIRQ);
  modport slave  (input nE, nSEL, RW, A, DIN, output DOUT, DOE, nIRQ);
endinterface

// File: rtl/spi_master_n.sv
// Byte-wide SPI master with NCS chip selects, programmable divider,
// CPOL/CPHA/LSB-first modes, overrun flag and completion interrupt.
// Everything runs on MHZ48; the CPU strobe is resynchronised.
module spi_master_n #(
  parameter int         NCS       = 4,
  parameter logic [7:0] RESET_DIV = 8'd59
) (
  input  logic           MHZ48,
  input  logic           nRES,
  spi_master_n_if.slave  bus,
  output logic           SCLK,
  output logic           MOSI,
  input  logic           MISO,
  output logic [NCS-1:0] nSS
);

  typedef enum logic {IDLE, RUN} state_t;

  // bus synchronisers: nESync[2] is the previous synced value for edge detect
  logic [2:0]      nESync;
  logic [1:0]      nSelSync, rwSync;
  logic [1:0][1:0] aSync;
  logic [1:0][7:0] dinSync;

  // access holding registers
  logic       holdVld, holdRw;
  logic [1:0] holdA;
  logic [7:0] holdDin;

  // programmer-visible state
  logic [3:0] ctrl;
  logic [7:0] div, rx;
  logic       done, ovr, busy;

  // shifter
  state_t     state, stateNext;
  logic [7:0] cnt, divEff, tx, rxSh, rxNext;
  logic [3:0] edgeK;
  logic [2:0] outIdx;
  logic       commit, load, start, tc, lastEdge, leading, txBit;
  logic       wrData, wrCtrl, wrDiv, wrCs, rdData, rdStatus;
  logic       cpol, cpha, lsbf;
  logic [7:0] csRead;

  assign cpol = ctrl[0];
  assign cpha = ctrl[1];
  assign lsbf = ctrl[2];

  assign load   = ~nESync[1] & ~nSelSync[1];
  assign commit = nESync[1] & ~nESync[2] & holdVld;

  assign wrData   = commit & ~holdRw & (holdA == 2'd0);
  assign wrCtrl   = commit & ~holdRw & (holdA == 2'd1);
  assign wrDiv    = commit & ~holdRw & (holdA == 2'd2);
  assign wrCs     = commit & ~holdRw & (holdA == 2'd3);
  assign rdData   = commit &  holdRw & (holdA == 2'd0);
  assign rdStatus = commit &  holdRw & (holdA == 2'd1);

  assign busy     = (state == RUN);
  assign start    = wrData & ~busy;
  assign divEff   = (div == 8'd0) ? 8'd1 : div;
  assign tc       = (cnt == divEff);
  assign lastEdge = busy & tc & (edgeK == 4'd15);
  assign leading  = ~edgeK[0];
  // leading edges emit the current bit (CPHA=1), trailing edges the next one (CPHA=0)
  assign outIdx   = leading ? edgeK[3:1] : edgeK[3:1] + 3'd1;
  assign txBit    = tx[lsbf ? outIdx : 3'd7 - outIdx];
  assign rxNext   = lsbf ? {MISO, rxSh[7:1]} : {rxSh[6:0], MISO};

  // resynchronise the asynchronous CPU bus and hold the access being strobed
  always_ff @(posedge MHZ48) begin
    if (!nRES) begin
      nESync   <= 3'b111;
      nSelSync <= 2'b11;
      rwSync   <= 2'b11;
      aSync    <= '0;
      dinSync  <= '0;
      holdVld  <= 1'b0;
      holdRw   <= 1'b1;
      holdA    <= 2'd0;
      holdDin  <= 8'd0;
    end else begin
      nESync   <= {nESync[1:0], bus.nE};
      nSelSync <= {nSelSync[0], bus.nSEL};
      rwSync   <= {rwSync[0], bus.RW};
      aSync    <= {aSync[0], bus.A};
      dinSync  <= {dinSync[0], bus.DIN};
      if (load) begin
        holdVld <= 1'b1;
        holdRw  <= rwSync[1];
        holdA   <= aSync[1];
        holdDin <= dinSync[1];
      end else if (commit) begin
        holdVld <= 1'b0;
      end
    end
  end

  // transfer state register
  always_ff @(posedge MHZ48) begin
    if (!nRES) state <= IDLE;
    else       state <= stateNext;
  end

  // IDLE -> RUN on an accepted DATA write, back after the 16th edge
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (start) stateNext = RUN;
      RUN:  if (lastEdge) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // registers, divider, clock generation and shifting
  always_ff @(posedge MHZ48) begin
    if (!nRES) begin
      ctrl  <= 4'd0;
      div   <= RESET_DIV;
      nSS   <= '1;
      done  <= 1'b0;
      ovr   <= 1'b0;
      rx    <= 8'd0;
      rxSh  <= 8'd0;
      tx    <= 8'd0;
      cnt   <= 8'd0;
      edgeK <= 4'd0;
      SCLK  <= 1'b0;
      MOSI  <= 1'b1;
    end else begin
      if (wrCtrl && !busy) ctrl <= holdDin[3:0];
      if (wrDiv && !busy)  div  <= holdDin;
      if (wrCs)            nSS  <= holdDin[NCS-1:0];
      if (wrData && busy)  ovr  <= 1'b1;
      if (rdStatus)        ovr  <= 1'b0;
      // completion outranks a clear landing on the same cycle
      if (start || rdData) done <= 1'b0;
      if (lastEdge)        done <= 1'b1;

      if (start) begin
        tx    <= holdDin;
        rxSh  <= 8'd0;
        cnt   <= 8'd0;
        edgeK <= 4'd0;
        if (!cpha) MOSI <= lsbf ? holdDin[0] : holdDin[7];
      end

      if (!busy) begin
        SCLK <= cpol;
      end else if (!tc) begin
        cnt <= cnt + 8'd1;
      end else begin
        cnt   <= 8'd0;
        edgeK <= edgeK + 4'd1;
        SCLK  <= ~SCLK;
        if (leading) begin
          if (cpha) MOSI <= txBit;
          else      rxSh <= rxNext;
        end else begin
          if (cpha)                    rxSh <= rxNext;
          else if (edgeK != 4'd15)     MOSI <= txBit;
        end
        if (edgeK == 4'd15) begin
          rx   <= cpha ? rxNext : rxSh;
          SCLK <= cpol;
        end
      end
    end
  end

  // CS readback with unused positions reading as 1
  always_comb begin
    csRead = 8'hFF;
    csRead[NCS-1:0] = nSS;
  end

  // register read mux, driven straight off the raw address
  always_comb begin
    bus.DOUT = 8'd0;
    case (bus.A)
      2'd0: bus.DOUT = rx;
      2'd1: bus.DOUT = {busy, done, ovr, 1'b0, ctrl};
      2'd2: bus.DOUT = div;
      2'd3: bus.DOUT = csRead;
      default: bus.DOUT = 8'd0;
    endcase
  end

  assign bus.DOE  = ~bus.nSEL & ~bus.nE & bus.RW;
  assign bus.nIRQ = ~(ctrl[3] & done);

endmodule

// File: tb/tb_spi_master_n.sv
// Directed bench for spi_master_n: CPU bus tasks plus a polled SPI slave.
module tb_spi_master_n;
  logic       MHZ48 = 1'b0;
  logic       nRES  = 1'b0;
  logic       MISO  = 1'b1;
  logic       SCLK, MOSI;
  logic [3:0] nSS;
  int checks = 0;
  int failures = 0;

  spi_master_n_if bus();

  spi_master_n #(.NCS(4), .RESET_DIV(8'd59)) dut (
    .MHZ48(MHZ48), .nRES(nRES), .bus(bus.slave),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .nSS(nSS)
  );

  always #5 MHZ48 = ~MHZ48;

  task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
    @(negedge MHZ48); bus.nSEL = 1'b0; bus.RW = 1'b0; bus.A = a; bus.DIN = d;
    @(negedge MHZ48); bus.nE = 1'b0;
    repeat (4) @(negedge MHZ48);
    bus.nE = 1'b1;
    repeat (4) @(negedge MHZ48);
    bus.nSEL = 1'b1; bus.RW = 1'b1;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [7:0] d);
    @(negedge MHZ48); bus.nSEL = 1'b0; bus.RW = 1'b1; bus.A = a;
    @(negedge MHZ48); bus.nE = 1'b0;
    repeat (2) @(negedge MHZ48);
    d = bus.DOUT;
    repeat (2) @(negedge MHZ48);
    bus.nE = 1'b1;
    repeat (4) @(negedge MHZ48);
    bus.nSEL = 1'b1;
  endtask

  // SPI slave polled on negedges: drives MISO, captures MOSI, measures half
  // periods, busy cycles and nIRQ against ~(ien & done)
  task automatic slaveRun(input logic [7:0] sb, input logic cpha, input logic lsbf,
                          input int halfCyc, input int maxEdges, input logic ien,
                          output logic [7:0] mosiB, output int edges, output int badGaps,
                          output int busyC, output int irqBad);
    int idx, cap, gap, tmo;
    logic prev;
    idx = 0; cap = 0; gap = 0; tmo = 0;
    edges = 0; badGaps = 0; busyC = 0; irqBad = 0; mosiB = 8'h00;
    prev = SCLK;
    MISO = cpha ? 1'b1 : sb[lsbf ? 0 : 7];
    while (edges < maxEdges && tmo < 3000) begin
      @(negedge MHZ48);
      gap++; tmo++;
      if (dut.busy) busyC++;
      if (bus.nIRQ !== !(ien && dut.done)) irqBad++;
      if (SCLK !== prev) begin
        prev = SCLK;
        edges++;
        if (edges > 1 && gap != halfCyc) badGaps++;
        gap = 0;
        if ((edges % 2) == 1) begin
          if (!cpha) begin
            if (cap < 8) begin
              if (lsbf) mosiB[cap] = MOSI; else mosiB[7-cap] = MOSI;
              cap++;
            end
          end else begin
            if (idx < 8) MISO = sb[lsbf ? idx : 7 - idx];
            idx++;
          end
        end else begin
          if (!cpha) begin
            idx++;
            if (idx < 8) MISO = sb[lsbf ? idx : 7 - idx];
          end else if (cap < 8) begin
            if (lsbf) mosiB[cap] = MOSI; else mosiB[7-cap] = MOSI;
            cap++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    nRES = 1'b0;
    repeat (2) @(negedge MHZ48);
    checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", SCLK); end
    checks++; if (MOSI !== 1'b1) begin failures++; $display("FAIL rst_mosi got=%b exp=1", MOSI); end
    checks++; if (nSS !== 4'hF) begin failures++; $display("FAIL rst_nss got=%h exp=f", nSS); end
    checks++; if (bus.nIRQ !== 1'b1) begin failures++; $display("FAIL rst_nirq got=%b exp=1", bus.nIRQ); end
    nRES = 1'b1;
    @(negedge MHZ48); bus.nSEL = 1'b0; bus.RW = 1'b1; bus.A = 2'd1; bus.nE = 1'b0;
    #1;
    checks++; if (bus.DOE !== 1'b1) begin failures++; $display("FAIL doe_on got=%b exp=1", bus.DOE); end
    bus.RW = 1'b0;
    #1;
    checks++; if (bus.DOE !== 1'b0) begin failures++; $display("FAIL doe_write got=%b exp=0", bus.DOE); end
    bus.RW = 1'b1;
    repeat (3) @(negedge MHZ48);
    bus.nE = 1'b1;
    repeat (4) @(negedge MHZ48);
    bus.nSEL = 1'b1;
    busRead(2'd2, d);
    checks++; if (d !== 8'd59) begin failures++; $display("FAIL rst_div got=%h exp=3b", d); end
    busRead(2'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_status got=%h exp=00", d); end
    busRead(2'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_rx got=%h exp=00", d); end
    busRead(2'd3, d);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL rst_cs got=%h exp=ff", d); end
  endtask

  task automatic test_mode0();
    logic [7:0] d, mb;
    int e, g, b, ib;
    busWrite(2'd3, 8'h0E);
    checks++; if (nSS !== 4'hE) begin failures++; $display("FAIL m0_nss got=%h exp=e", nSS); end
    busWrite(2'd2, 8'h01);
    busWrite(2'd1, 8'h00);
    fork
      slaveRun(8'h3C, 1'b0, 1'b0, 2, 16, 1'b0, mb, e, g, b, ib);
      busWrite(2'd0, 8'hA5);
    join
    checks++; if (mb !== 8'hA5) begin failures++; $display("FAIL m0_mosi got=%h exp=a5", mb); end
    checks++; if (e !== 16) begin failures++; $display("FAIL m0_edges got=%0d exp=16", e); end
    checks++; if (g !== 0) begin failures++; $display("FAIL m0_halfper got=%0d bad exp=0", g); end
    checks++; if (b !== 32) begin failures++; $display("FAIL m0_busy got=%0d exp=32", b); end
    busRead(2'd1, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL m0_status got=%h exp=40", d); end
    busRead(2'd0, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL m0_rx got=%h exp=3c", d); end
    busRead(2'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL m0_status2 got=%h exp=00", d); end
  endtask

  task automatic test_mode3_lsbf();
    logic [7:0] d, mb;
    int e, g, b, ib;
    busWrite(2'd1, 8'h07);
    busWrite(2'd2, 8'h03);
    repeat (2) @(negedge MHZ48);
    checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL m3_idle got=%b exp=1", SCLK); end
    fork
      slaveRun(8'h5A, 1'b1, 1'b1, 4, 16, 1'b0, mb, e, g, b, ib);
      busWrite(2'd0, 8'h81);
    join
    checks++; if (mb !== 8'h81) begin failures++; $display("FAIL m3_mosi got=%h exp=81", mb); end
    checks++; if (e !== 16) begin failures++; $display("FAIL m3_edges got=%0d exp=16", e); end
    checks++; if (g !== 0) begin failures++; $display("FAIL m3_halfper got=%0d bad exp=0", g); end
    checks++; if (b !== 64) begin failures++; $display("FAIL m3_busy got=%0d exp=64", b); end
    checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL m3_sclk_end got=%b exp=1", SCLK); end
    busRead(2'd0, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL m3_rx got=%h exp=5a", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d, mb;
    int e, g, b, ib;
    busWrite(2'd1, 8'h00);
    busWrite(2'd2, 8'h03);
    fork
      slaveRun(8'h00, 1'b0, 1'b0, 4, 16, 1'b0, mb, e, g, b, ib);
      begin
        busWrite(2'd0, 8'h11);
        busWrite(2'd0, 8'h22);
        busWrite(2'd1, 8'h0F);
        busWrite(2'd2, 8'h05);
      end
    join
    checks++; if (mb !== 8'h11) begin failures++; $display("FAIL ovr_mosi got=%h exp=11", mb); end
    checks++; if (b !== 64) begin failures++; $display("FAIL ovr_busy got=%0d exp=64", b); end
    busRead(2'd1, d);
    checks++; if (d !== 8'h60) begin failures++; $display("FAIL ovr_status got=%h exp=60", d); end
    busRead(2'd1, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL ovr_cleared got=%h exp=40", d); end
    busRead(2'd2, d);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL ovr_div got=%h exp=03", d); end
    busRead(2'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL ovr_rx got=%h exp=00", d); end
  endtask

  task automatic test_irq();
    logic [7:0] d, mb;
    int e, g, b, ib;
    busWrite(2'd2, 8'h01);
    busWrite(2'd1, 8'h08);
    fork
      slaveRun(8'h96, 1'b0, 1'b0, 2, 16, 1'b1, mb, e, g, b, ib);
      busWrite(2'd0, 8'h3C);
    join
    checks++; if (ib !== 0) begin failures++; $display("FAIL irq_track got=%0d bad exp=0", ib); end
    checks++; if (bus.nIRQ !== 1'b0) begin failures++; $display("FAIL irq_low got=%b exp=0", bus.nIRQ); end
    busRead(2'd1, d);
    checks++; if (d !== 8'h48) begin failures++; $display("FAIL irq_status got=%h exp=48", d); end
    busRead(2'd0, d);
    checks++; if (d !== 8'h96) begin failures++; $display("FAIL irq_rx got=%h exp=96", d); end
    checks++; if (bus.nIRQ !== 1'b1) begin failures++; $display("FAIL irq_release got=%b exp=1", bus.nIRQ); end
    busWrite(2'd1, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, mb;
    int e, g, b, ib;
    busWrite(2'd2, 8'h01);
    busWrite(2'd3, 8'h0E);
    fork
      slaveRun(8'hFF, 1'b0, 1'b0, 2, 7, 1'b0, mb, e, g, b, ib);
      busWrite(2'd0, 8'h00);
    join
    checks++; if (e !== 7 || SCLK !== 1'b1 || MOSI !== 1'b0) begin
      failures++; $display("FAIL mid_pre got=%0d/%b/%b exp=7/1/0", e, SCLK, MOSI); end
    nRES = 1'b0;
    @(negedge MHZ48);
    checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL mid_sclk got=%b exp=0", SCLK); end
    checks++; if (MOSI !== 1'b1) begin failures++; $display("FAIL mid_mosi got=%b exp=1", MOSI); end
    checks++; if (nSS !== 4'hF) begin failures++; $display("FAIL mid_nss got=%h exp=f", nSS); end
    checks++; if (dut.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", dut.busy); end
    nRES = 1'b1;
    fork
      slaveRun(8'hC3, 1'b0, 1'b0, 60, 16, 1'b0, mb, e, g, b, ib);
      busWrite(2'd0, 8'h5A);
    join
    checks++; if (e !== 16) begin failures++; $display("FAIL mid_edges got=%0d exp=16", e); end
    checks++; if (g !== 0) begin failures++; $display("FAIL mid_halfper got=%0d bad exp=0", g); end
    checks++; if (b !== 960) begin failures++; $display("FAIL mid_busy_len got=%0d exp=960", b); end
    checks++; if (mb !== 8'h5A) begin failures++; $display("FAIL mid_mosi_byte got=%h exp=5a", mb); end
    busRead(2'd0, d);
    checks++; if (d !== 8'hC3) begin failures++; $display("FAIL mid_rx got=%h exp=c3", d); end
  endtask

  initial begin
    bus.nE = 1'b1; bus.nSEL = 1'b1; bus.RW = 1'b1; bus.A = 2'd0; bus.DIN = 8'h00;
    test_reset();
    test_mode0();
    test_mode3_lsbf();
    test_overrun();
    test_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
